decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 73 +++++++
 rtl/decode_stage_imm_gen.sv | 41 ++++
 rtl/decode_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32I decode stage:
//   - base opcode constants (instr[6:0])
//   - op-class enum carried on out_op
//   - decode FSM state enum
//   - helpers that map an opcode to its class and to its rd-write behaviour
// ----------------------------------------------------------------------------
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OPIMM   = 4'd7,
        CLS_OP      = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd15
    } op_class_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Anything outside the ten supported base opcodes is illegal
    // (this includes MISC-MEM / FENCE).
    function automatic op_class_e classify(input logic [6:0] opcode);
        op_class_e c;
        case (opcode)
            OPC_LUI:    c = CLS_LUI;
            OPC_AUIPC:  c = CLS_AUIPC;
            OPC_JAL:    c = CLS_JAL;
            OPC_JALR:   c = CLS_JALR;
            OPC_BRANCH: c = CLS_BRANCH;
            OPC_LOAD:   c = CLS_LOAD;
            OPC_STORE:  c = CLS_STORE;
            OPC_OPIMM:  c = CLS_OPIMM;
            OPC_OP:     c = CLS_OP;
            OPC_SYSTEM: c = CLS_SYSTEM;
            default:    c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    // Classes that produce an architectural rd write.
    function automatic logic writes_rd(input op_class_e c);
        logic we;
        case (c)
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
            CLS_LOAD, CLS_OPIMM, CLS_OP: we = 1'b1;
            default:                     we = 1'b0;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// ----------------------------------------------------------------------------
// imm_gen
// Purely combinational RV32I immediate generator. The format (I/S/B/U/J) is
// selected from the opcode; the result is sign-extended to 32 bits. R-type
// and unknown opcodes yield zero.
// Ports:
//   i_instr  in  32  instruction word
//   o_imm    out 32  sign-extended immediate
// ----------------------------------------------------------------------------
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);

    op_class_e w_cls;

    assign w_cls = classify(i_instr[6:0]);

    always_comb begin
        o_imm = '0;
        case (w_cls)
            CLS_LOAD, CLS_OPIMM, CLS_JALR, CLS_SYSTEM:
                o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            CLS_STORE:
                o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            CLS_BRANCH:
                o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                o_imm = {i_instr[31:12], 12'b0};
            CLS_JAL:
                o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// RV32I decode stage with a busy-bit scoreboard. One instruction is in flight
// at a time: IDLE accepts, READ waits for the one-cycle register-file read,
// HOLD presents the decoded bundle until execute takes it.
// Ports:
//   clk, reset                      clock, async active-high reset
//   instr_valid/instr/pc_in         fetch offer
//   instr_ready                     decode accepts this cycle
//   flush                           discard in-flight instruction
//   rf_rs1/rf_rs2                   register-file read addresses
//   rf_data1/rf_data2               read data, one cycle after the address
//   wb_valid/wb_rd                  retiring writeback (clears busy bit)
//   out_valid/out_ready             bundle handshake to execute
//   out_pc/out_rs1_val/out_rs2_val/out_imm/out_rd/out_funct3/
//   out_funct7b5/out_op/out_we/out_illegal   decoded bundle
// ----------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    output logic        instr_ready,
    input  logic        flush,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic [3:0]  out_op,
    output logic        out_we,
    output logic        out_illegal
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] w_imm;
    op_class_e   w_cls;
    logic        w_hazard;
    logic        w_accept;
    logic        w_handshake;

    assign w_cls = classify(instr[6:0]);

    imm_gen u_imm_gen (
        .i_instr (instr),
        .o_imm   (w_imm)
    );

    // Conservative: rs1/rs2/rd fields are checked even when the format does
    // not use them, so no per-format field decoding is needed here.
    assign w_hazard = r_busy[instr[19:15]] | r_busy[instr[24:20]] | r_busy[instr[11:7]];

    // The bundle is valid exactly while the FSM sits in HOLD, so an async
    // reset or a flush drops it with the state.
    assign out_valid = (r_state == S_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        rf_rs1      = r_rs1;
        rf_rs2      = r_rs2;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Read addresses come straight from the offered word so the
                // register file is read in the accept cycle.
                rf_rs1      = instr[19:15];
                rf_rs2      = instr[24:20];
                instr_ready = !w_hazard && !flush && !reset;
                w_accept    = instr_valid && !w_hazard && !flush && !reset;
                if (w_accept) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_handshake = out_ready && !flush;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        if (w_handshake && out_we && (out_rd != 5'd0)) begin
            w_busy_nxt[out_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rs1        <= '0;
            r_rs2        <= '0;
            out_pc       <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_op       <= '0;
            out_we       <= 1'b0;
            out_illegal  <= 1'b0;
            out_rs1_val  <= '0;
            out_rs2_val  <= '0;
        end else begin
            // Accept edge: latch the instruction fields and immediate.
            if (w_accept) begin
                r_rs1        <= instr[19:15];
                r_rs2        <= instr[24:20];
                out_pc       <= pc_in;
                out_imm      <= w_imm;
                out_rd       <= instr[11:7];
                out_funct3   <= instr[14:12];
                out_funct7b5 <= instr[30];
                out_op       <= w_cls;
                out_we       <= writes_rd(w_cls);
                out_illegal  <= (w_cls == CLS_ILLEGAL);
            end
            // READ->HOLD edge: register-file data is now valid.
            if ((r_state == S_READ) && !flush) begin
                out_rs1_val <= rf_data1;
                out_rs2_val <= rf_data2;
            end
        end
    end

endmodule
